// File: rtl/alu_issue_if.sv
// Handshake and data bundle between the decode stage, the alu_issue buffer and the ALU.
// The slave modport is the alu_issue side; master is the side that drives the instruction stream.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_ill;

    modport slave (
        input  in_valid, in_insn, in_rs_data, in_rt_data,
        input  wb_en, wb_rd, wb_data,
        input  out_ready,
        output in_ready, out_valid,
        output data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
        output out_rd, out_wen, out_ill
    );

    modport master (
        output in_valid, in_insn, in_rs_data, in_rt_data,
        output wb_en, wb_rd, wb_data,
        output out_ready,
        input  in_ready, out_valid,
        input  data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
        input  out_rd, out_wen, out_ill
    );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage issue buffer: decodes R-type/addi into ALU operands and holds them in a 2-entry skid buffer.
// Optional same-cycle writeback forwarding is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        resetn,
    alu_issue_if.slave  bus
);

    localparam logic [1:0] FULL_LVL = 2'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = FULL_LVL
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic        accept_s;
    logic        pop_s;
    logic [4:0]  rs_idx_s;
    logic [4:0]  rt_idx_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    entry_t      new_s;

`ifdef ALU_ISSUE_FWD_EN
    logic        unused_s;
    assign unused_s = ^{bus.in_insn[1:0]};
`else
    logic        unused_s;
    assign unused_s = ^{bus.in_insn[1:0], bus.wb_en, bus.wb_rd, bus.wb_data};
`endif

    function automatic entry_t decode(input logic [31:0] insn,
                                      input logic [31:0] rs_val,
                                      input logic [31:0] rt_val);
        entry_t e;
        e = '0;
        case (insn[31:27])
            5'b00000: begin
                e.a   = rs_val;
                e.b   = rt_val;
                e.op  = insn[6:2];
                e.sh  = insn[11:7];
                e.rd  = insn[26:22];
                e.wen = (insn[26:22] != 5'd0);
            end
            5'b00101: begin
                e.a   = rs_val;
                e.b   = {{15{insn[16]}}, insn[16:0]};
                e.rd  = insn[26:22];
                e.wen = (insn[26:22] != 5'd0);
            end
            default: begin
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Operand selection: $0 always reads zero and wins over any forwarded writeback.
    always_comb begin
        rs_idx_s = bus.in_insn[21:17];
        rt_idx_s = bus.in_insn[16:12];
        rs_val_s = 32'd0;
        rt_val_s = 32'd0;
        if (rs_idx_s == 5'd0) begin
            rs_val_s = 32'd0;
        end
`ifdef ALU_ISSUE_FWD_EN
        else if (bus.wb_en && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs_idx_s)) begin
            rs_val_s = bus.wb_data;
        end
`endif
        else begin
            rs_val_s = bus.in_rs_data;
        end
        if (rt_idx_s == 5'd0) begin
            rt_val_s = 32'd0;
        end
`ifdef ALU_ISSUE_FWD_EN
        else if (bus.wb_en && (bus.wb_rd != 5'd0) && (bus.wb_rd == rt_idx_s)) begin
            rt_val_s = bus.wb_data;
        end
`endif
        else begin
            rt_val_s = bus.in_rt_data;
        end
        new_s = decode(bus.in_insn, rs_val_s, rt_val_s);
    end

    // Buffer occupancy: head is what the ALU sees, tail only exists while FULL.
    always_comb begin
        accept_s    = bus.in_valid & in_ready_q;
        pop_s       = out_valid_q & bus.out_ready;
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    head_d  = new_s;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && pop_s) begin
                    head_d  = new_s;
                    state_d = ONE;
                end else if (accept_s) begin
                    tail_d  = new_s;
                    state_d = FULL;
                end else if (pop_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State and entry registers; in_ready stays low until the first edge after reset release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.data_operandA  = head_q.a;
    assign bus.data_operandB  = head_q.b;
    assign bus.ctrl_ALUopcode = head_q.op;
    assign bus.ctrl_shiftamt  = head_q.sh;
    assign bus.out_rd         = head_q.rd;
    assign bus.out_wen        = head_q.wen;
    assign bus.out_ill        = head_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue: expected entries are queued on accept and compared on pop.
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    logic clock;
    logic resetn;
    int   total;
    int   bad;
    exp_t sb[$];
    exp_t pend;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    alu_issue_if bus();

    alu_issue #(.DEPTH(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                input logic [4:0] sh, input logic [4:0] rd, input logic wen,
                                input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.sh = sh; e.rd = rd; e.wen = wen; e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] rtyp(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh, input logic [4:0] op);
        return {5'b00000, rd, rs, rt, sh, op, 2'b00};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs, input logic [16:0] imm);
        return {5'b00101, rd, rs, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] insn, input logic [31:0] rs, input logic [31:0] rt, input exp_t e);
        bus.in_insn    = insn;
        bus.in_rs_data = rs;
        bus.in_rt_data = rt;
        pend           = e;
        bus.in_valid   = 1'b1;
    endtask

    // One clock: score any pop and record any accept seen at the coming edge.
    task automatic cycle();
        exp_t e;
        logic acc;
        logic pp;
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready;
        if (pp) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("opA", bus.data_operandA, e.a);
                chk("opB", bus.data_operandB, e.b);
                chk("aluop", 32'(bus.ctrl_ALUopcode), 32'(e.op));
                chk("shamt", 32'(bus.ctrl_shiftamt), 32'(e.sh));
                chk("wen", 32'(bus.out_wen), 32'(e.wen));
                chk("ill", 32'(bus.out_ill), 32'(e.ill));
                if (!e.ill) chk("rd", 32'(bus.out_rd), 32'(e.rd));
            end
        end
        if (acc) sb.push_back(pend);
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clock = 1'b0;
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_insn = 32'd0;
        bus.in_rs_data = 32'd0;
        bus.in_rt_data = 32'd0;
        bus.wb_en = 1'b0;
        bus.wb_rd = 5'd0;
        bus.wb_data = 32'd0;
        bus.out_ready = 1'b1;
        pend = '0;
`ifdef ALU_ISSUE_FWD_EN
        fwd_a = 32'hDEADBEEF;
        fwd_b = 32'hDEADBEEF;
`else
        fwd_a = 32'h00000000;
        fwd_b = 32'h00000077;
`endif

        // reset values while held
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_A", bus.data_operandA, 32'd0);
        chk("rst_B", bus.data_operandB, 32'd0);
        chk("rst_ill", 32'(bus.out_ill), 32'd0);
        #2 resetn = 1'b1;
        cycle();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // R-type, one-cycle latency
        drive(rtyp(5'd4, 5'd1, 5'd2, 5'd5, 5'b00011), 32'h0000000F, 32'h000000F0,
              mk(32'h0000000F, 32'h000000F0, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_A", bus.data_operandA, 32'h0000000F);
        cycle();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // addi back-to-back at full throughput
        drive(addi(5'd6, 5'd7, 17'h1FFFF), 32'h00000010, 32'h00001234,
              mk(32'h00000010, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0));
        cycle();
        drive(addi(5'd0, 5'd7, 17'h1FFFF), 32'h00000010, 32'h00001234,
              mk(32'h00000010, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        cycle();
        drive(addi(5'd8, 5'd0, 17'h00005), 32'h00000010, 32'h00001234,
              mk(32'h00000000, 32'h00000005, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0));
        cycle();
        chk("thru_in_ready", 32'(bus.in_ready), 32'd1);
        chk("thru_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        cycle();

        // same-cycle writeback forwarding and the $0 rule
        bus.wb_en = 1'b1;
        bus.wb_rd = 5'd3;
        bus.wb_data = 32'hDEADBEEF;
        drive(rtyp(5'd5, 5'd3, 5'd0, 5'd0, 5'd0), 32'h00000000, 32'h00000055,
              mk(fwd_a, 32'h00000000, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0));
        cycle();
        drive(rtyp(5'd5, 5'd0, 5'd3, 5'd0, 5'd0), 32'h00001234, 32'h00000077,
              mk(32'h00000000, fwd_b, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        bus.wb_en = 1'b0;
        cycle();

        // illegal opcode
        drive({5'b11111, 5'd9, 5'd1, 5'd2, 12'hABC}, 32'h00000011, 32'h00000022,
              mk(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1));
        cycle();
        bus.in_valid = 1'b0;
        chk("ill_flag", 32'(bus.out_ill), 32'd1);
        cycle();

        // backpressure: fill, stall a third, then drain in order
        bus.out_ready = 1'b0;
        drive(rtyp(5'd10, 5'd1, 5'd2, 5'd0, 5'd1), 32'h00000100, 32'h00000200,
              mk(32'h00000100, 32'h00000200, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0));
        cycle();
        chk("bp1_in_ready", 32'(bus.in_ready), 32'd1);
        drive(addi(5'd11, 5'd2, 17'h00010), 32'h00000300, 32'h0,
              mk(32'h00000300, 32'h00000010, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0));
        cycle();
        chk("bp2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp2_valid", 32'(bus.out_valid), 32'd1);
        bus.wb_en = 1'b1;
        bus.wb_rd = 5'd1;
        bus.wb_data = 32'hCAFEF00D;
        drive(rtyp(5'd12, 5'd8, 5'd9, 5'd3, 5'd2), 32'h00000400, 32'h00000500,
              mk(32'h00000400, 32'h00000500, 5'd2, 5'd3, 5'd12, 1'b1, 1'b0));
        cycle();
        chk("bp3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_A", bus.data_operandA, 32'h00000100);
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        chk("pop_in_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        bus.in_valid = 1'b0;
        chk("accpop_valid", 32'(bus.out_valid), 32'd1);
        cycle();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        chk("hold_A", bus.data_operandA, 32'h00000400);

        // asynchronous reset while FULL
        bus.out_ready = 1'b0;
        drive(rtyp(5'd13, 5'd1, 5'd2, 5'd4, 5'd6), 32'h00000999, 32'h00000888,
              mk(32'h00000999, 32'h00000888, 5'd6, 5'd4, 5'd13, 1'b1, 1'b0));
        cycle();
        drive({5'b11111, 27'd0}, 32'h0, 32'h0, mk(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1));
        cycle();
        bus.in_valid = 1'b0;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_A", bus.data_operandA, 32'd0);
        chk("mid_B", bus.data_operandB, 32'd0);
        chk("mid_op", 32'(bus.ctrl_ALUopcode), 32'd0);
        chk("mid_sh", 32'(bus.ctrl_shiftamt), 32'd0);
        chk("mid_rd", 32'(bus.out_rd), 32'd0);
        chk("mid_wen", 32'(bus.out_wen), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        bus.out_ready = 1'b1;
        #3 resetn = 1'b1;
        cycle();
        chk("rel2_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel2_valid", 32'(bus.out_valid), 32'd0);

        // buffer works again after reset
        drive(rtyp(5'd14, 5'd5, 5'd6, 5'd7, 5'd8), 32'h12345678, 32'h9ABCDEF0,
              mk(32'h12345678, 32'h9ABCDEF0, 5'd8, 5'd7, 5'd14, 1'b1, 1'b0));
        cycle();
        bus.in_valid = 1'b0;
        cycle();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue buffer that sits directly upstream of the ALU (`alub`). It accepts one decoded-format instruction per cycle together with register-file read data, and forms `data_operandA`, `data_operandB`, `ctrl_ALUopcode` and `ctrl_shiftamt`. It optionally forwards a same-cycle writeback value and holds results in a 2-entry skid buffer, so upstream `in_ready` is a registered signal.

## Interface
- `DEPTH`, 2: skid buffer entries; fixed at 2, other values unsupported.
- `clock` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: buffer can accept; registered.
- `in_insn` input 32: instruction word.
- `in_rs_data` input 32: register-file value of rs.
- `in_rt_data` input 32: register-file value of rt.
- `wb_en` input 1: writeback this cycle.
- `wb_rd` input 5: writeback destination.
- `wb_data` input 32: writeback value.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: ALU/execute consumes head.
- `data_operandA` output 32: ALU operand A.
- `data_operandB` output 32: ALU operand B.
- `ctrl_ALUopcode` output 5: ALU opcode.
- `ctrl_shiftamt` output 5: shift amount.
- `out_rd` output 5: destination register.
- `out_wen` output 1: result is written back.
- `out_ill` output 1: illegal opcode flag.

## Operation
- Fields: opcode `[31:27]`, rd `[26:22]`, rs `[21:17]`, rt `[16:12]`, shamt `[11:7]`, aluop `[6:2]`, imm `[16:0]`.
- **R-type**, opcode `00000`:
  - A = rs value; B = rt value.
  - ALUopcode = aluop; shiftamt = shamt; wen = (rd≠0).
- **addi**, opcode `00101`:
  - A = rs value; B = imm sign-extended from bit 16 to 32 bits.
  - ALUopcode = `00000`; shiftamt = 0; wen = (rd≠0).
- **Any other opcode:** A = B = 0, ALUopcode = 0, shiftamt = 0, wen = 0, ill = 1.
- **Register $0:** rs = 0 or rt = 0 reads as 0, regardless of input data or forwarding.
- **Forwarding (see Configuration):** if wb_en and wb_rd≠0 and wb_rd = rs, the rs value is wb_data. The rt value follows the same rule.
- Decode and forwarding are evaluated in the accept cycle and captured into the entry. Later writebacks do not modify stored entries.
- **Buffer states:** EMPTY (0 entries), ONE (1), FULL (2).
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - EMPTY + accept → ONE.
  - ONE + accept & !pop → FULL.
  - ONE + pop & !accept → EMPTY.
  - ONE + accept & pop → ONE; head is replaced by the new entry.
  - FULL + pop → ONE; the second entry becomes head.
  - FULL never accepts.
- FIFO order strictly preserved; no entry dropped or duplicated.
- Outputs reflect the head entry. When out_valid = 0, data outputs hold their last value.

## Timing
- **Reset (asynchronous, resetn low):**
  - state EMPTY; in_ready = 1 after release, 0 while asserted.
  - out_valid = 0; data_operandA/B = 0; ctrl_ALUopcode = 0; ctrl_shiftamt = 0.
  - out_rd = 0; out_wen = 0; out_ill = 0.
- Reset mid-operation discards all entries immediately.
- **Latency:** an instruction accepted at edge N appears on the outputs with out_valid = 1 after edge N; one cycle.
- **Throughput:** 1 instruction/cycle while out_ready = 1.
- in_ready = (state ≠ FULL), registered; it never depends combinationally on out_ready.
- With out_ready held low: two accepts fill the buffer, and in_ready drops after the second accept edge.
- Upstream must hold in_insn/in_*_data stable while in_valid & !in_ready. The block does not check this.
- Output entry is stable while out_valid & !out_ready.

## Configuration
- Macro `ALU_ISSUE_FWD_EN`.
- **Defined:** writeback forwarding active as specified in Operation.
- **Undefined:** wb_en/wb_rd/wb_data are ignored; operands come only from in_rs_data/in_rt_data, and the $0 rule still applies.

## Test plan
- **Reset:** resetn low mid-FULL → out_valid = 0, all outputs 0 asynchronously; in_ready = 1 on the first edge after release.
- **R-type:** rs = 1 (0x0000000F), rt = 2 (0x000000F0), aluop `00011`, shamt 5 → next cycle A = 0x0000000F, B = 0x000000F0, ALUopcode `00011`, shiftamt 5, out_wen = 1.
- **addi:** imm = 0x1FFFF, rs data 0x00000010 → B = 0xFFFFFFFF, ALUopcode `00000`. Repeat with rd = 0 → out_wen = 0.
- **Forwarding:** same-cycle wb_en, wb_rd = rs = 3, wb_data 0xDEADBEEF, in_rs_data 0 → A = 0xDEADBEEF with the macro defined, A = 0 without it. Same stimulus with rs = 0 → A = 0 either way.
- **Backpressure:** out_ready = 0, offer 3 instructions → first two accepted, in_ready = 0. Raise out_ready → outputs appear in order 1, 2, 3 with no loss; simultaneous accept/pop in ONE keeps out_valid = 1.
- **Illegal:** opcode `11111` → out_ill = 1, out_wen = 0, A = B = 0.
